// File: rtl/bch_syndrome_serial_if.sv
// ---------------------------------------------------------------------------
// bch_syndrome_serial_if
// Stream bundle for the bit-serial BCH syndrome generator.
//   in_valid / in_ready / in_bit      : one received-codeword bit per handshake
//   out_valid / out_ready / syndromes : packed S_1..S_2T, held until consumed
//   out_zero                          : only when SYND_ZERO_FLAG_EN is defined
// Modports:
//   master : the side that feeds bits and consumes syndromes (e.g. testbench)
//   slave  : the syndrome generator itself
// Parameters M (field degree) and T (correction capability) size the bus.
// ---------------------------------------------------------------------------
interface bch_syndrome_serial_if #(
  parameter int M = 4,
  parameter int T = 2
);
  logic               in_valid;
  logic               in_ready;
  logic               in_bit;
  logic               out_valid;
  logic               out_ready;
  logic [2*T*M-1:0]   syndromes;
`ifdef SYND_ZERO_FLAG_EN
  logic               out_zero;
`endif

  modport master (
    output in_valid,
    output in_bit,
    output out_ready,
    input  in_ready,
    input  out_valid,
`ifdef SYND_ZERO_FLAG_EN
    input  out_zero,
`endif
    input  syndromes
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  out_ready,
    output in_ready,
    output out_valid,
`ifdef SYND_ZERO_FLAG_EN
    output out_zero,
`endif
    output syndromes
  );
endinterface

// File: rtl/bch_syndrome_serial.sv
// ---------------------------------------------------------------------------
// bch_syndrome_serial
// Bit-serial BCH syndrome generator over GF(2^M). Received bits arrive
// highest coefficient first (r_{N-1} .. r_0), one per accepted handshake.
// Each syndrome S_j (j = 1..2T) is accumulated in Horner form:
//     S_j <= S_j * alpha^j  XOR  in_bit
// After N bits S_j = sum_i r_i * alpha^(i*j). The result is then held on
// the output until out_valid && out_ready, after which the accumulators
// clear and the next codeword may start on the following cycle.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : bch_syndrome_serial_if.slave (input bit stream, syndrome output)
//
// Optional feature macro: SYND_ZERO_FLAG_EN
//   When defined, bus.out_zero is a registered flag that is 1 while the held
//   result has every S_j == 0 (error-free codeword).
// ---------------------------------------------------------------------------
module bch_syndrome_serial #(
  parameter int           M         = 4,
  parameter int           N         = 15,
  parameter int           T         = 2,
  parameter logic [M:0]   PRIM_POLY = 5'b10011
) (
  input  logic                 clk,
  input  logic                 rst,
  bch_syndrome_serial_if.slave bus
);

  localparam int NS    = 2 * T;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  // Multiply by alpha: shift up one power and fold x^M back through the
  // primitive polynomial.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
    logic [M-1:0] r;
    r = {v[M-2:0], 1'b0};
    if (v[M-1]) begin
      r = r ^ PRIM_POLY[M-1:0];
    end
    return r;
  endfunction

  // Multiply by alpha^j as j chained xtime stages. j is an elaboration-time
  // constant at every call site, so this flattens into a fixed XOR network.
  function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] v, input int j);
    logic [M-1:0] r;
    r = v;
    for (int k = 0; k < j; k++) begin
      r = xtime(r);
    end
    return r;
  endfunction

  logic [0:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [M-1:0]     s_reg  [NS];
  logic [M-1:0]     s_next [NS];
  logic [M-1:0]     s_prod [NS];
  logic             in_ready_int;
  logic             out_valid_int;
  logic             accept;
  logic             last_bit;

  assign in_ready_int  = (state_reg == ST_ACCUM);
  assign out_valid_int = (state_reg == ST_DONE);
  assign accept        = bus.in_valid && in_ready_int;
  assign last_bit      = (cnt_reg == CNT_W'(N - 1));

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;

  // One Horner stage per syndrome; the received bit is the constant term.
  for (genvar gi = 0; gi < NS; gi++) begin : g_synd
    assign s_prod[gi] = mul_alpha_pow(s_reg[gi], gi + 1);
    assign s_next[gi] = {s_prod[gi][M-1:1], s_prod[gi][0] ^ bus.in_bit};
    assign bus.syndromes[gi*M +: M] = s_reg[gi];
  end

`ifdef SYND_ZERO_FLAG_EN
  logic          zero_reg;
  logic [NS-1:0] s_next_nz;

  for (genvar gi = 0; gi < NS; gi++) begin : g_nz
    assign s_next_nz[gi] = |s_next[gi];
  end

  assign bus.out_zero = zero_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_ACCUM;
      cnt_reg   <= '0;
      for (int k = 0; k < NS; k++) begin
        s_reg[k] <= '0;
      end
`ifdef SYND_ZERO_FLAG_EN
      zero_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_ACCUM: begin
          if (accept) begin
            for (int k = 0; k < NS; k++) begin
              s_reg[k] <= s_next[k];
            end
            if (last_bit) begin
              cnt_reg   <= '0;
              state_reg <= ST_DONE;
`ifdef SYND_ZERO_FLAG_EN
              // Evaluated on the final bit so the flag is ready together
              // with out_valid.
              zero_reg  <= ~|s_next_nz;
`endif
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            for (int k = 0; k < NS; k++) begin
              s_reg[k] <= '0;
            end
            state_reg <= ST_ACCUM;
`ifdef SYND_ZERO_FLAG_EN
            zero_reg  <= 1'b0;
`endif
          end
        end
        default: begin
          state_reg <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule
